// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the per-stage tracking entry, the memory FSM states and the zero-register constant.
package pipe_ctrl_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0] dest;
      logic       WB_En;
      logic       MEM_R_En;
      logic       MEM_W_En;
   } track_entry_t;

   localparam track_entry_t TRACK_EMPTY = '0;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;

   // A slot only produces a value worth waiting for if it writes a non-zero register.
   function automatic logic slot_hits(input track_entry_t e, input logic [4:0] src);
      return e.WB_En && (e.dest != REG_ZERO) && (e.dest == src);
   endfunction

endpackage

// File: rtl/hazard_track_pipe.sv
// Three-slot shadow of the EXE/MEM/WB destination and memory-access bits.
// Holds on freeze and inserts a bubble into EXE when the issuing instruction is squashed.
module hazard_track_pipe
   import pipe_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         hold_i,
   input  logic         bubble_i,
   input  track_entry_t issue_i,
   output track_entry_t exe_o,
   output track_entry_t mem_o,
   output track_entry_t wb_o
);

   track_entry_t exe_q, mem_q, wb_q;
   track_entry_t exe_d;

   assign exe_d = bubble_i ? TRACK_EMPTY : issue_i;

   // NOTE: sequential state uses non-blocking assignments so every slot samples the pre-edge value of its neighbour.
   always_ff @(posedge clk) begin
      if (!rst) begin
         exe_q <= TRACK_EMPTY;
         mem_q <= TRACK_EMPTY;
         wb_q  <= TRACK_EMPTY;
      end else if (!hold_i) begin
         exe_q <= exe_d;
         mem_q <= exe_q;
         wb_q  <= mem_q;
      end
   end

   assign exe_o = exe_q;
   assign mem_o = mem_q;
   assign wb_o  = wb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Generates stall / loadForwardStall / Flush for the ID->EXE register from a private
// shadow of the downstream stages, plus saturating stall and freeze counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter bit          FORWARD_EN   = 1'b1,
   parameter bit          WB_BYPASS    = 1'b1,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_src1,
   input  logic [4:0]  id_src2,
   input  logic        id_uses_src2,
   input  logic [4:0]  id_dest,
   input  logic        id_WB_En,
   input  logic        id_MEM_R_En,
   input  logic        id_MEM_W_En,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        stall,
   output logic        loadForwardStall,
   output logic        Flush,
   output logic        front_hold,
   output logic [31:0] stall_count,
   output logic [31:0] freeze_count
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   track_entry_t issue_entry, exe_slot, mem_slot, wb_slot;
   mem_state_e   mem_state_q;
   logic [2:0]   flush_cnt_q;
   logic [31:0]  stall_cnt_q, freeze_cnt_q;
   logic         hazard, mem_busy;
   logic         unused_slot_bits;

   assign issue_entry = '{dest: id_dest, WB_En: id_WB_En,
                          MEM_R_En: id_MEM_R_En, MEM_W_En: id_MEM_W_En};

   hazard_track_pipe u_track (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (loadForwardStall),
      .bubble_i (stall | Flush | ~id_valid),
      .issue_i  (issue_entry),
      .exe_o    (exe_slot),
      .mem_o    (mem_slot),
      .wb_o     (wb_slot)
   );

   assign mem_busy = (mem_slot.MEM_R_En | mem_slot.MEM_W_En) & ~mem_ready;

   // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hazard = 1'b0;
      if (FORWARD_EN) begin
         hazard = exe_slot.MEM_R_En &
                  (slot_hits(exe_slot, id_src1) | (id_uses_src2 & slot_hits(exe_slot, id_src2)));
      end else begin
         hazard = slot_hits(exe_slot, id_src1) | (id_uses_src2 & slot_hits(exe_slot, id_src2)) |
                  slot_hits(mem_slot, id_src1) | (id_uses_src2 & slot_hits(mem_slot, id_src2));
         if (!WB_BYPASS)
            hazard = hazard | slot_hits(wb_slot, id_src1) |
                     (id_uses_src2 & slot_hits(wb_slot, id_src2));
      end
   end

   // Freeze outranks flush, which outranks stall; reset forces everything quiet.
   always_comb begin
      loadForwardStall = rst & mem_busy;
      Flush            = rst & (br_taken | (flush_cnt_q != 3'd0)) & ~loadForwardStall;
      stall            = rst & id_valid & hazard & ~Flush & ~loadForwardStall;
      front_hold       = stall | loadForwardStall;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         flush_cnt_q  <= 3'd0;
         mem_state_q  <= MEM_IDLE;
         stall_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         if (!loadForwardStall) begin
            if (br_taken)
               flush_cnt_q <= FLUSH_LOAD;
            else if (flush_cnt_q != 3'd0)
               flush_cnt_q <= flush_cnt_q - 3'd1;
         end

         // WAIT only marks an access in progress; the freeze itself follows mem_busy directly.
         case (mem_state_q)
            MEM_IDLE: if (mem_busy)  mem_state_q <= MEM_WAIT;
            MEM_WAIT: if (mem_ready) mem_state_q <= MEM_IDLE;
            default:                 mem_state_q <= MEM_IDLE;
         endcase

         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (loadForwardStall && (freeze_cnt_q != '1))
            freeze_cnt_q <= freeze_cnt_q + 32'd1;
      end
   end

   assign stall_count  = stall_cnt_q;
   assign freeze_count = freeze_cnt_q;

   // Slot fields the compare never needs in some configurations.
   assign unused_slot_bits = ^{wb_slot, exe_slot.MEM_W_En};

endmodule
